mux_scan_capture: RTL and testbench
===================================

// Module: mux_scan_capture
// PURPOSE
//  Sequential scanner that drives the select {a,b,c} and enable e of the
//  multiplexer8_1 stage, samples its y / y_inverted outputs channel by channel,
//  and assembles the 8 selected inputs into one byte.
//  It sits directly downstream of, and also controls, the 8:1 mux.
//  It hands the byte plus a per-channel integrity mask to the next stage over a
//  valid/ready handshake.
// PARAMETERS
//  SETTLE_CYCLES  1  cycles after each select change before sampling (>=1)
//  EN_LEVEL       1  level driven on mux_e while scanning; ~EN_LEVEL when idle
// PORTS
//  clk         in   1  rising-edge clock
//  rst_n       in   1  asynchronous active-low reset
//  start       in   1  request one 8-channel scan; sampled only in IDLE
//  busy        out  1  high in SETTLE/SAMPLE/DONE
//  sel         out  3  mux select, sel[2]=a, sel[1]=b, sel[0]=c; channel i[sel]
//  mux_e       out  1  mux enable e
//  y_in        in   1  mux output y
//  y_inv_in    in   1  mux output y_inverted
//  data_out    out  8  data_out[k] = y sampled while sel==k
//  err_mask    out  8  err_mask[k]=1 if y_in==y_inv_in when channel k was sampled
//  data_valid  out  1  data_out/err_mask valid; held until accepted
//  data_ready  in   1  downstream accepts when data_valid & data_ready
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, sel=0, mux_e=~EN_LEVEL, busy=0.
//   Also data_out=0, err_mask=0, data_valid=0, settle counter=0.
//  FSM: IDLE -> SETTLE -> SAMPLE -> (SETTLE | DONE) -> IDLE.
//  IDLE: sel=0, mux_e=~EN_LEVEL. On start=1: go to SETTLE, sel=0,
//   mux_e=EN_LEVEL, counter=0, data_out/err_mask cleared.
//  SETTLE: counter increments each cycle; after SETTLE_CYCLES cycles go to SAMPLE.
//   sel is stable throughout.
//  SAMPLE (one cycle): at the closing edge, data_out[sel]<=y_in and
//   err_mask[sel]<=(y_in==y_inv_in).
//   If sel==7: go to DONE. Else sel<=sel+1, counter=0, go to SETTLE.
//  DONE: data_valid=1, mux_e=~EN_LEVEL, sel held at 7.
//   data_out and err_mask are frozen while data_valid=1.
//   On data_valid&data_ready: data_valid<=0 and go to IDLE.
//   If start=1 in that same cycle, go straight to SETTLE for a new scan
//   (back-to-back, no idle bubble).
//  Latency: data_valid rises 8*(SETTLE_CYCLES+1) clock edges after the
//   start-accept edge (16 edges at default).
//  start while busy (SETTLE/SAMPLE, or DONE without a handshake) is ignored,
//   not queued.
//  data_ready while data_valid=0 has no effect.
//  sel never wraps past 7 within a scan. A new scan always restarts at channel 0.
//  rst_n low mid-scan: partial byte discarded, no data_valid pulse.
//   Scanning resumes only on a new start after reset release.
//  All outputs are registered; no combinational path from inputs to outputs.
// TESTING
//  1 i=8'hA5, healthy mux, start pulse -> sel steps 0..7, 2 cycles each;
//    data_valid at edge 16; data_out=8'hA5, err_mask=8'h00.
//  2 y_inv_in forced equal to y_in on channel 3 only -> err_mask=8'h08,
//    data_out still equals i.
//  3 data_ready held low 5 cycles after valid -> data_valid and data_out
//    stable all 5 cycles; a start pulse in that window is ignored.
//  4 data_ready=1 and start=1 in the accept cycle, i changed to 8'h3C ->
//    next data_valid 16 edges later with 8'h3C; no IDLE cycle between scans.
//  5 rst_n low during channel 4 -> outputs at reset values immediately
//    (async); no data_valid until a fresh start completes.
//  6 SETTLE_CYCLES=3, i=8'hFF -> 4 cycles per channel, data_valid at
//    edge 32, data_out=8'hFF.

Source files
------------

// File: rtl/mux_scan_capture.sv
// ============================================================================
// mux_scan_capture: steps an 8:1 mux through all channels and captures a byte
// Revision: 1.0
// ============================================================================
`default_nettype none

module mux_scan_capture #(
  parameter int   SETTLE_CYCLES = 1,
  parameter logic EN_LEVEL      = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       busy,
  output logic [2:0] sel,
  output logic       mux_e,
  input  logic       y_in,
  input  logic       y_inv_in,
  output logic [7:0] data_out,
  output logic [7:0] err_mask,
  output logic       data_valid,
  input  logic       data_ready
);

  localparam int             CW       = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sel        <= 3'd0;
      mux_e      <= ~EN_LEVEL;
      busy       <= 1'b0;
      cnt        <= '0;
      data_out   <= 8'h00;
      err_mask   <= 8'h00;
      data_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          sel <= 3'd0;
          if (start) begin
            state    <= SETTLE;
            mux_e    <= EN_LEVEL;
            busy     <= 1'b1;
            cnt      <= '0;
            data_out <= 8'h00;
            err_mask <= 8'h00;
          end else begin
            mux_e <= ~EN_LEVEL;
            busy  <= 1'b0;
          end
        end
        SETTLE: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) state <= SAMPLE;
        end
        SAMPLE: begin
          // A healthy mux always drives complementary y / y_inverted
          data_out[sel] <= y_in;
          err_mask[sel] <= (y_in == y_inv_in);
          if (sel == 3'd7) begin
            state      <= DONE;
            data_valid <= 1'b1;
            mux_e      <= ~EN_LEVEL;
          end else begin
            sel   <= sel + 3'd1;
            cnt   <= '0;
            state <= SETTLE;
          end
        end
        DONE: begin
          if (data_ready) begin
            data_valid <= 1'b0;
            sel        <= 3'd0;
            if (start) begin
              state    <= SETTLE;
              mux_e    <= EN_LEVEL;
              cnt      <= '0;
              data_out <= 8'h00;
              err_mask <= 8'h00;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mux_scan_capture.sv
// ============================================================================
// tb_mux_scan_capture: directed self-checking bench with a behavioural 8:1 mux
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mux_scan_capture;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, data_ready;
  logic       busy, mux_e, data_valid;
  logic [2:0] sel;
  logic [7:0] data_out, err_mask;
  logic [7:0] i_vec;
  logic       force_err;
  logic       y, y_inv;

  logic       start2, data_ready2;
  logic       busy2, mux_e2, data_valid2;
  logic [2:0] sel2;
  logic [7:0] data_out2, err_mask2;
  logic [7:0] i_vec2;
  logic       y2, y_inv2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Mux models: channel 3 of the first one can be made to fail integrity
  assign y      = i_vec[sel];
  assign y_inv  = (force_err && sel == 3'd3) ? y : ~y;
  assign y2     = i_vec2[sel2];
  assign y_inv2 = ~y2;

  mux_scan_capture dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .sel(sel),
    .mux_e(mux_e), .y_in(y), .y_inv_in(y_inv), .data_out(data_out),
    .err_mask(err_mask), .data_valid(data_valid), .data_ready(data_ready)
  );

  mux_scan_capture #(.SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .sel(sel2),
    .mux_e(mux_e2), .y_in(y2), .y_inv_in(y_inv2), .data_out(data_out2),
    .err_mask(err_mask2), .data_valid(data_valid2), .data_ready(data_ready2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_scan();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!data_valid && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic accept();
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({busy, sel, mux_e, data_valid, data_out, err_mask} !== {1'b0, 3'd0, 1'b0, 1'b0, 16'h0000}) begin
      errors++;
      $display("FAIL reset: busy=%b sel=%0d e=%b v=%b d=%h m=%h, want all zero",
               busy, sel, mux_e, data_valid, data_out, err_mask);
    end
  endtask

  task automatic test_basic_scan();
    int n;
    int bad_sel;
    i_vec = 8'hA5;
    force_err = 1'b0;
    start_scan();
    checks++;
    if ({busy, mux_e, sel} !== {1'b1, 1'b1, 3'd0}) begin
      errors++;
      $display("FAIL accept: busy=%b e=%b sel=%0d, want 1 1 0", busy, mux_e, sel);
    end
    n = 0;
    bad_sel = 0;
    while (!data_valid && n < 200) begin
      tick();
      n++;
      if (!data_valid && sel !== 3'(n / 2)) bad_sel++;
    end
    checks++;
    if (bad_sel != 0) begin
      errors++;
      $display("FAIL sel_sequence: %0d wrong steps, want 0", bad_sel);
    end
    checks++;
    if (n != 16) begin
      errors++;
      $display("FAIL latency: valid after %0d edges, want 16", n);
    end
    checks++;
    if ({data_out, err_mask, sel, mux_e, busy} !== {8'hA5, 8'h00, 3'd7, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL scan_result: d=%h m=%h sel=%0d e=%b busy=%b, want a5 00 7 0 1",
               data_out, err_mask, sel, mux_e, busy);
    end
    accept();
    checks++;
    if ({data_valid, busy, sel} !== {1'b0, 1'b0, 3'd0}) begin
      errors++;
      $display("FAIL handshake: v=%b busy=%b sel=%0d, want 0 0 0", data_valid, busy, sel);
    end
  endtask

  task automatic test_integrity();
    int n;
    i_vec = 8'h5A;
    force_err = 1'b1;
    start_scan();
    wait_valid(n);
    force_err = 1'b0;
    checks++;
    if ({data_out, err_mask} !== {8'h5A, 8'h08}) begin
      errors++;
      $display("FAIL integrity: d=%h m=%h, want 5a 08", data_out, err_mask);
    end
  endtask

  // Continues from the pending result of test_integrity
  task automatic test_backpressure();
    int unstable = 0;
    for (int k = 0; k < 5; k++) begin
      start = (k == 2);
      i_vec = 8'hFF;
      tick();
      if (data_valid !== 1'b1 || data_out !== 8'h5A || err_mask !== 8'h08) unstable++;
    end
    start = 1'b0;
    checks++;
    if (unstable != 0) begin
      errors++;
      $display("FAIL backpressure_hold: %0d unstable cycles, want 0", unstable);
    end
    accept();
    checks++;
    if ({data_valid, busy} !== 2'b00) begin
      errors++;
      $display("FAIL start_ignored: v=%b busy=%b, want 0 0", data_valid, busy);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    i_vec = 8'hA5;
    start_scan();
    wait_valid(n);
    i_vec = 8'h3C;
    start = 1'b1;
    data_ready = 1'b1;
    tick();
    start = 1'b0;
    data_ready = 1'b0;
    checks++;
    if ({data_valid, busy, sel, mux_e} !== {1'b0, 1'b1, 3'd0, 1'b1}) begin
      errors++;
      $display("FAIL b2b_restart: v=%b busy=%b sel=%0d e=%b, want 0 1 0 1",
               data_valid, busy, sel, mux_e);
    end
    wait_valid(n);
    checks++;
    if (n != 16 || data_out !== 8'h3C || err_mask !== 8'h00) begin
      errors++;
      $display("FAIL b2b_result: edges=%0d d=%h m=%h, want 16 3c 00", n, data_out, err_mask);
    end
    accept();
  endtask

  task automatic test_reset_midscan();
    int n;
    int seen_valid = 0;
    i_vec = 8'hC3;
    start_scan();
    for (int k = 0; k < 8; k++) tick();
    checks++;
    if (sel !== 3'd4) begin
      errors++;
      $display("FAIL midscan_channel: sel=%0d, want 4", sel);
    end
    #2 rst_n = 1'b0;
    #1;
    test_reset();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (data_valid || busy) seen_valid++;
    end
    checks++;
    if (seen_valid != 0) begin
      errors++;
      $display("FAIL no_resume: %0d active cycles after reset, want 0", seen_valid);
    end
    start_scan();
    wait_valid(n);
    checks++;
    if (n != 16 || data_out !== 8'hC3) begin
      errors++;
      $display("FAIL fresh_scan: edges=%0d d=%h, want 16 c3", n, data_out);
    end
    accept();
  endtask

  task automatic test_long_settle();
    int n = 0;
    i_vec2 = 8'hFF;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    while (!data_valid2 && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (n != 32 || data_out2 !== 8'hFF || err_mask2 !== 8'h00) begin
      errors++;
      $display("FAIL settle3: edges=%0d d=%h m=%h, want 32 ff 00", n, data_out2, err_mask2);
    end
    data_ready2 = 1'b1;
    tick();
    data_ready2 = 1'b0;
    checks++;
    if ({data_valid2, busy2} !== 2'b00) begin
      errors++;
      $display("FAIL settle3_accept: v=%b busy=%b, want 0 0", data_valid2, busy2);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    data_ready = 1'b0;
    start2 = 1'b0;
    data_ready2 = 1'b0;
    i_vec = 8'h00;
    i_vec2 = 8'h00;
    force_err = 1'b0;
    tick();
    tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_reset();
    test_basic_scan();
    test_integrity();
    test_backpressure();
    test_back_to_back();
    test_reset_midscan();
    test_long_settle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
